// File: rtl/h14tx_period_scheduler.sv
// h14tx_period_scheduler: HDMI 1.4 TX period sequencer shared by the three TMDS encoders.
// Issues video preamble/guard ahead of each active line and packs data islands into
// horizontal blanking. Raw timing is delayed so the preamble can lead the active edge.
// Optional build macro H14TX_SCHED_STATS_EN adds island_cnt / pkt_cnt statistics outputs.

package h14tx_period_pkg;
    typedef enum logic [2:0] {
        PERIOD_CONTROL        = 3'd0,
        PERIOD_VIDEO_PREAMBLE = 3'd1,
        PERIOD_VIDEO_GUARD    = 3'd2,
        PERIOD_VIDEO_ACTIVE   = 3'd3,
        PERIOD_DI_PREAMBLE    = 3'd4,
        PERIOD_DI_GUARD       = 3'd5,
        PERIOD_DI_ACTIVE      = 3'd6
    } period_t;
endpackage

module h14tx_period_scheduler
    import h14tx_period_pkg::*;
#(
    parameter int LOOKAHEAD   = 10,
    parameter int MAX_PACKETS = 18,
    parameter int BLANK_W     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [4:0] pkt_avail,
    output logic       pkt_pop,
    output logic [4:0] pkt_word_idx,
    output period_t    period,
    output logic [1:0] ctl0,
    output logic [1:0] ctl1,
    output logic [1:0] ctl2,
    output logic       video_de,
    output logic       abort_err
`ifdef H14TX_SCHED_STATS_EN
    ,
    output logic [15:0] island_cnt,
    output logic [15:0] pkt_cnt
`endif
);

    typedef enum logic [2:0] {
        S_CTRL, S_VPRE, S_VGUARD, S_VACT, S_DPRE, S_DGL, S_DACT, S_DGT
    } state_t;

    // Timing delay line: {vsync, hsync, de}. The FSM reacts at the sampling edge, so the
    // outputs lag that edge by exactly LOOKAHEAD clocks (line stages plus output register).
    logic [LOOKAHEAD-1:0][2:0] dly_q, dly_d;
    logic [2:0]                out_q, out_d;

    generate
        for (genvar gi = 0; gi < LOOKAHEAD; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign dly_d[gi] = {vsync_in, hsync_in, de_in};
            end else begin : g_tail
                assign dly_d[gi] = dly_q[gi-1];
            end
        end
    endgenerate

    assign out_d = dly_q[LOOKAHEAD-1];

    logic               de_prev_q;
    logic               de_rise;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [BLANK_W-1:0] prev_blank_q, prev_blank_d;
    logic [BLANK_W-1:0] slots_fit;
    logic [4:0]         n_cap, n_calc;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       armed_q, armed_d;
    logic [4:0] n_q, n_d;
    logic [4:0] pcnt_q, pcnt_d;
    logic [4:0] idx_q, idx_d;
    logic       pop_q, pop_d;
    logic       abort_q, abort_d;
    period_t    period_q, period_d;
    logic [1:0] ctl1_q, ctl1_d, ctl2_q, ctl2_d;
    logic       island_busy;

    assign de_rise = de_in & ~de_prev_q;

    // Blank-length measurement and packet budget for the island after the current line.
    always_comb begin
        blank_cnt_d  = blank_cnt_q;
        prev_blank_d = prev_blank_q;
        slots_fit    = '0;
        n_cap        = '0;
        n_calc       = '0;
        if (de_rise) begin
            prev_blank_d = blank_cnt_q;
            blank_cnt_d  = '0;
        end else if (!de_in && blank_cnt_q != '1) begin
            blank_cnt_d = blank_cnt_q + 1'b1;
        end
        // 38 = 4 lead-in + 12 island framing + 12 control + 10 video preamble/guard.
        if (prev_blank_q >= BLANK_W'(70)) begin
            slots_fit = (prev_blank_q - BLANK_W'(38)) >> 5;
            if (slots_fit > BLANK_W'(MAX_PACKETS)) n_cap = 5'(MAX_PACKETS);
            else                                   n_cap = slots_fit[4:0];
            n_calc = (pkt_avail < n_cap) ? pkt_avail : n_cap;
        end
    end

    // Period FSM next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        n_d         = n_q;
        pcnt_d      = pcnt_q;
        idx_d       = idx_q;
        abort_d     = abort_q;
        island_busy = (state_q == S_DPRE) || (state_q == S_DGL) ||
                      (state_q == S_DACT) || (state_q == S_DGT);
        case (state_q)
            S_CTRL: begin
                if (de_rise) begin
                    state_d = S_VPRE;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (armed_q) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3) begin
                        armed_d = 1'b0;
                        cnt_d   = '0;
                        if (n_calc != 5'd0) begin
                            state_d = S_DPRE;
                            n_d     = n_calc;
                        end
                    end
                end
            end
            S_VPRE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin state_d = S_VGUARD; cnt_d = '0; end
            end
            S_VGUARD: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin state_d = S_VACT; cnt_d = '0; end
            end
            S_VACT: begin
                // Leave on the clock where the delayed de is about to drop.
                if (!dly_q[LOOKAHEAD-1][0]) begin
                    state_d = S_CTRL;
                    armed_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DPRE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin state_d = S_DGL; cnt_d = '0; end
            end
            S_DGL: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DACT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    pcnt_d  = '0;
                end
            end
            S_DACT: begin
                if (idx_q == 5'd31) begin
                    idx_d = '0;
                    if (pcnt_q == n_q - 5'd1) state_d = S_DGT;
                    else                      pcnt_d  = pcnt_q + 5'd1;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_DGT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd1) begin state_d = S_CTRL; cnt_d = '0; end
            end
            default: state_d = S_CTRL;
        endcase
        // An early active line truncates the island; unsent packets stay in the FIFO.
        if (island_busy && de_rise) begin
            state_d = S_VPRE;
            cnt_d   = '0;
            abort_d = 1'b1;
        end
        if (state_d != S_DACT) idx_d = '0;
        pop_d = (state_d == S_DACT) && (idx_d == 5'd0);

        period_d = PERIOD_CONTROL;
        ctl1_d   = 2'b00;
        ctl2_d   = 2'b00;
        case (state_d)
            S_VPRE:   begin period_d = PERIOD_VIDEO_PREAMBLE; ctl1_d = 2'b01; end
            S_VGUARD: period_d = PERIOD_VIDEO_GUARD;
            S_VACT:   period_d = PERIOD_VIDEO_ACTIVE;
            S_DPRE:   begin period_d = PERIOD_DI_PREAMBLE; ctl1_d = 2'b01; ctl2_d = 2'b01; end
            S_DGL:    period_d = PERIOD_DI_GUARD;
            S_DACT:   period_d = PERIOD_DI_ACTIVE;
            S_DGT:    period_d = PERIOD_DI_GUARD;
            default:  period_d = PERIOD_CONTROL;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q        <= '0;
            out_q        <= '0;
            de_prev_q    <= 1'b0;
            blank_cnt_q  <= '0;
            prev_blank_q <= '0;
            state_q      <= S_CTRL;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            n_q          <= '0;
            pcnt_q       <= '0;
            idx_q        <= '0;
            pop_q        <= 1'b0;
            abort_q      <= 1'b0;
            period_q     <= PERIOD_CONTROL;
            ctl1_q       <= '0;
            ctl2_q       <= '0;
        end else begin
            dly_q        <= dly_d;
            out_q        <= out_d;
            de_prev_q    <= de_in;
            blank_cnt_q  <= blank_cnt_d;
            prev_blank_q <= prev_blank_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            n_q          <= n_d;
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pop_q        <= pop_d;
            abort_q      <= abort_d;
            period_q     <= period_d;
            ctl1_q       <= ctl1_d;
            ctl2_q       <= ctl2_d;
        end
    end

    assign pkt_pop      = pop_q;
    assign pkt_word_idx = idx_q;
    assign period       = period_q;
    assign ctl0         = out_q[2:1];
    assign ctl1         = ctl1_q;
    assign ctl2         = ctl2_q;
    assign video_de     = out_q[0];
    assign abort_err    = abort_q;

`ifdef H14TX_SCHED_STATS_EN
    logic [15:0] island_cnt_q, island_cnt_d, pkt_cnt_q, pkt_cnt_d;

    // Completed-island and popped-packet counters, both free-running with wrap.
    always_comb begin
        island_cnt_d = island_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        if (state_q == S_DGT && state_d == S_CTRL) island_cnt_d = island_cnt_q + 16'd1;
        if (pop_d)                                  pkt_cnt_d    = pkt_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            island_cnt_q <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            island_cnt_q <= island_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign island_cnt = island_cnt_q;
    assign pkt_cnt    = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Testbench for h14tx_period_scheduler: an event-level timeline model fills expected
// periods per clock; a monitor pops one expected entry per clock and compares.
module tb_h14tx_period_scheduler;
    import h14tx_period_pkg::*;

    localparam int SZ = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       de_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [4:0] pkt_avail = 5'd0;
    logic       pkt_pop;
    logic [4:0] pkt_word_idx;
    period_t    period;
    logic [1:0] ctl0, ctl1, ctl2;
    logic       video_de;
    logic       abort_err;
`ifdef H14TX_SCHED_STATS_EN
    logic [15:0] island_cnt, pkt_cnt;
`endif

    h14tx_period_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .de_in        (de_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .pkt_avail    (pkt_avail),
        .pkt_pop      (pkt_pop),
        .pkt_word_idx (pkt_word_idx),
        .period       (period),
        .ctl0         (ctl0),
        .ctl1         (ctl1),
        .ctl2         (ctl2),
        .video_de     (video_de),
        .abort_err    (abort_err)
`ifdef H14TX_SCHED_STATS_EN
        ,
        .island_cnt   (island_cnt),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        period_t    per;
        logic [4:0] idx;
        logic       vde;
        logic [1:0] c0;
        logic       abrt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   shown  = 0;

    // Timeline model: one expected period/index per clock edge, plus input history.
    period_t    slot_p [SZ];
    logic [4:0] slot_i [SZ];
    logic [2:0] hist   [SZ];
    int   cyc = 0;
    int   blank, pblank, pending, isl_end;
    logic de_prev, vde_prev, abort_m;

    function automatic bit is_island(period_t p);
        return (p == PERIOD_DI_PREAMBLE) || (p == PERIOD_DI_GUARD) || (p == PERIOD_DI_ACTIVE);
    endfunction

    task automatic set_slot(input int i, input period_t p, input int ix);
        if (i >= 0 && i < SZ) begin
            slot_p[i] = p;
            slot_i[i] = 5'(ix);
        end
    endtask

    task automatic model_step(input logic r, input logic de, input logic hs, input logic vs,
                              input logic [4:0] avail);
        int   n;
        int   nk;
        int   b;
        logic vde;
        logic [1:0] c0;
        exp_t e;
        n = cyc;
        if (r) begin
            for (int i = n; i < n + 700; i++) set_slot(i, PERIOD_CONTROL, 0);
            for (int i = n - 10; i <= n; i++) if (i >= 0) hist[i] = 3'b000;
            blank = 0; pblank = 0; de_prev = 1'b0; vde_prev = 1'b0;
            pending = -1; isl_end = -1; abort_m = 1'b0;
        end else begin
            hist[n] = {vs, hs, de};
            if (de && !de_prev) begin
                if (n > 0 && is_island(slot_p[n-1])) begin
                    for (int i = n; i <= isl_end; i++) set_slot(i, PERIOD_CONTROL, 0);
                    abort_m = 1'b1;
                end
                if (!(n > 0 && (slot_p[n-1] == PERIOD_VIDEO_PREAMBLE ||
                                slot_p[n-1] == PERIOD_VIDEO_GUARD))) begin
                    for (int i = 0; i < 8; i++) set_slot(n + i, PERIOD_VIDEO_PREAMBLE, 0);
                    set_slot(n + 8, PERIOD_VIDEO_GUARD, 0);
                    set_slot(n + 9, PERIOD_VIDEO_GUARD, 0);
                    pending = -1;
                end
                pblank = blank;
                blank  = 0;
            end else if (!de && blank < 4095) begin
                blank = blank + 1;
            end
            de_prev = de;
        end
        vde = (n >= 10) ? hist[n-10][0]   : 1'b0;
        c0  = (n >= 10) ? hist[n-10][2:1] : 2'b00;
        if (!r) begin
            if (!vde && vde_prev) pending = n + 4;
            vde_prev = vde;
            if (n == pending) begin
                pending = -1;
                if (slot_p[n-1] == PERIOD_CONTROL && slot_p[n] == PERIOD_CONTROL) begin
                    nk = (pblank < 70) ? 0 : (pblank - 38) / 32;
                    if (nk > 18) nk = 18;
                    if (int'(avail) < nk) nk = int'(avail);
                    if (nk > 0) begin
                        for (int i = 0; i < 8; i++) set_slot(n + i, PERIOD_DI_PREAMBLE, 0);
                        set_slot(n + 8, PERIOD_DI_GUARD, 0);
                        set_slot(n + 9, PERIOD_DI_GUARD, 0);
                        b = n + 10;
                        for (int i = 0; i < 32 * nk; i++) set_slot(b + i, PERIOD_DI_ACTIVE, i % 32);
                        set_slot(b + 32 * nk, PERIOD_DI_GUARD, 0);
                        set_slot(b + 32 * nk + 1, PERIOD_DI_GUARD, 0);
                        isl_end = b + 32 * nk + 1;
                    end
                end
            end
            if (slot_p[n] == PERIOD_CONTROL && vde) slot_p[n] = PERIOD_VIDEO_ACTIVE;
        end
        e.cyc  = n;
        e.per  = slot_p[n];
        e.idx  = slot_i[n];
        e.vde  = vde;
        e.c0   = c0;
        e.abrt = abort_m;
        sb_q.push_back(e);
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            if (shown < 40) begin
                $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
                shown = shown + 1;
            end
        end
    endtask

    // Monitor: one expected entry per clock, compared just after the active edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("period", mon_e.cyc, 8'(period), 8'(mon_e.per));
            chk("pkt_word_idx", mon_e.cyc, 8'(pkt_word_idx), 8'(mon_e.idx));
            chk("pkt_pop", mon_e.cyc, 8'(pkt_pop),
                8'((mon_e.per == PERIOD_DI_ACTIVE) && (mon_e.idx == 5'd0)));
            chk("video_de", mon_e.cyc, 8'(video_de), 8'(mon_e.vde));
            chk("ctl0", mon_e.cyc, 8'(ctl0), 8'(mon_e.c0));
            chk("ctl1", mon_e.cyc, 8'(ctl1),
                8'((mon_e.per == PERIOD_VIDEO_PREAMBLE || mon_e.per == PERIOD_DI_PREAMBLE) ? 2'b01 : 2'b00));
            chk("ctl2", mon_e.cyc, 8'(ctl2), 8'((mon_e.per == PERIOD_DI_PREAMBLE) ? 2'b01 : 2'b00));
            chk("abort_err", mon_e.cyc, 8'(abort_err), 8'(mon_e.abrt));
        end
    end

    task automatic tick(input logic r, input logic de, input logic [4:0] avail, input bit rand_av);
        @(negedge clk);
        rst       = r;
        de_in     = de;
        hsync_in  = 1'($urandom_range(1, 0));
        vsync_in  = 1'($urandom_range(1, 0));
        pkt_avail = rand_av ? 5'($urandom_range(31, 0)) : avail;
        model_step(r, de, hsync_in, vsync_in, pkt_avail);
    endtask

    task automatic line(input int hi, input int lo, input logic [4:0] avail, input bit rand_av,
                        input int rst_at);
        for (int i = 0; i < hi; i++) tick(1'b0, 1'b1, avail, rand_av);
        for (int i = 0; i < lo; i++) tick(i == rst_at, 1'b0, avail, rand_av);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < SZ; i++) begin
            slot_p[i] = PERIOD_CONTROL;
            slot_i[i] = 5'd0;
            hist[i]   = 3'b000;
        end
        blank = 0; pblank = 0; pending = -1; isl_end = -1;
        de_prev = 1'b0; vde_prev = 1'b0; abort_m = 1'b0;

        repeat (3) tick(1'b1, 1'b0, 5'd0, 1'b0);
        repeat (5) tick(1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) line(16, 100, 5'd0, 1'b0, -1);    // no packets: video framing only
        repeat (3) line(16, 100, 5'd5, 1'b0, -1);    // N=1 islands
        repeat (2) line(16, 200, 5'd31, 1'b0, -1);   // N=5 island after the second line
        line(16, 60, 5'd31, 1'b0, -1);               // N=5 island cut short by de rise
        repeat (2) line(16, 100, 5'd5, 1'b0, -1);
        line(16, 100, 5'd5, 1'b0, 40);               // reset lands inside the data island
        repeat (2) line(16, 100, 5'd5, 1'b0, -1);
        repeat (25) line($urandom_range(40, 10), $urandom_range(300, 20), 5'd0, 1'b1, -1);
        repeat (5) tick(1'b0, 1'b0, 5'd0, 1'b0);
        @(posedge clk);
        #3;
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
